// File: rtl/matx_pkg.sv
// Shared constants, error codes and FSM state encoding for the MATX hex parser.
// Holds the tag string and a helper that returns one tag character by match position.
package matx_pkg;

    localparam int TAG_LEN = 8;
    localparam logic [8*TAG_LEN-1:0] TAG = "MATX_TAG";

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NO_TAG  = 2'd1;
    localparam logic [1:0] ERR_BAD_HEX = 2'd2;
    localparam logic [1:0] ERR_SHORT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_SEEK,
        S_HI,
        S_LO,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    // The first tag character sits in the most significant byte of the string literal.
    function automatic logic [7:0] tag_char(input logic [2:0] m);
        return TAG[8*(TAG_LEN-1-int'(m)) +: 8];
    endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder: char -> {is_hex, nibble}.
// Lowercase 'a'-'f' is accepted only when MATX_PARSER_LOWERCASE_EN is defined.
module hex_ascii_decode (
    input  logic [7:0] char_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o
);

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the if/else chain can leave it unassigned and infer a latch.
    always_comb begin
        is_hex_o = 1'b0;
        nibble_o = 4'd0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0];
        end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end
`ifdef MATX_PARSER_LOWERCASE_EN
        else if (char_i >= 8'h61 && char_i <= 8'h66) begin
            is_hex_o = 1'b1;
            nibble_o = char_i[3:0] + 4'd9;
        end
`else
        else begin
            is_hex_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/matx_hex_parser.sv
// Scans the SD sector buffer for "MATX_TAG", then decodes N_BYTES CRLF-separated
// two-digit hex lines into bytes streamed with their index over a valid/ready port.
module matx_hex_parser
    import matx_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int N_BYTES = 32,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    input  logic [7:0]        ram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_BYTES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              eob_q,   eob_d;   // address ADDR_MAX has been consumed
    logic              rd_q,    rd_d;    // TAG/LO: 0 = issue read, 1 = sample data
    logic [2:0]        m_q,     m_d;
    logic              nl_q,    nl_d;    // one LF already seen since the last byte
    logic [3:0]        hi_q,    hi_d;
    logic [7:0]        data_q,  data_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [1:0]        code_q,  code_d;

    logic       ch_is_hex;
    logic [3:0] ch_nibble;

    hex_ascii_decode u_dec (
        .char_i   (ram_dout),
        .is_hex_o (ch_is_hex),
        .nibble_o (ch_nibble)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            eob_q   <= 1'b0;
            rd_q    <= 1'b0;
            m_q     <= '0;
            nl_q    <= 1'b0;
            hi_q    <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            eob_q   <= eob_d;
            rd_q    <= rd_d;
            m_q     <= m_d;
            nl_q    <= nl_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        eob_d   = eob_q;
        rd_d    = rd_q;
        m_d     = m_q;
        nl_d    = nl_q;
        hi_d    = hi_q;
        data_d  = data_q;
        idx_d   = idx_q;
        code_d  = code_q;
        ram_en  = 1'b0;

        // Every sampled char moves the pointer on; the last address sets eob instead of wrapping.
        if ((state_q == S_SEEK) || ((state_q == S_TAG || state_q == S_LO) && rd_q)) begin
            if (addr_q == ADDR_MAX) begin
                eob_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_TAG;
                    addr_d  = '0;
                    eob_d   = 1'b0;
                    rd_d    = 1'b0;
                    m_d     = '0;
                    nl_d    = 1'b0;
                    idx_d   = '0;
                    code_d  = ERR_NONE;
                end
            end

            S_TAG: begin
                if (!rd_q) begin
                    ram_en = 1'b1;
                    rd_d   = 1'b1;
                end else begin
                    rd_d = 1'b0;
                    if (ram_dout == tag_char(m_q) && m_q == 3'(TAG_LEN - 1)) begin
                        state_d = S_HI;
                        nl_d    = 1'b0;
                    end else begin
                        if (ram_dout == tag_char(m_q)) begin
                            m_d = m_q + 3'd1;
                        end else begin
                            m_d = (ram_dout == tag_char(3'd0)) ? 3'd1 : 3'd0;
                        end
                        if (addr_q == ADDR_MAX) begin
                            state_d = S_ERR;
                            code_d  = ERR_NO_TAG;
                        end
                    end
                end
            end

            // Read-issue cycle for SEEK; running out of buffer here means the data is short.
            S_HI: begin
                if (eob_q) begin
                    state_d = S_ERR;
                    code_d  = ERR_SHORT;
                end else begin
                    ram_en  = 1'b1;
                    state_d = S_SEEK;
                end
            end

            S_SEEK: begin
                if (ram_dout == CR) begin
                    state_d = S_HI;
                end else if (ram_dout == LF) begin
                    if (nl_q) begin
                        state_d = S_ERR;
                        code_d  = ERR_SHORT;
                    end else begin
                        nl_d    = 1'b1;
                        state_d = S_HI;
                    end
                end else if (ch_is_hex) begin
                    hi_d    = ch_nibble;
                    state_d = S_LO;
                end else begin
                    state_d = S_ERR;
                    code_d  = ERR_BAD_HEX;
                end
            end

            S_LO: begin
                if (!rd_q) begin
                    if (eob_q) begin
                        state_d = S_ERR;
                        code_d  = ERR_SHORT;
                    end else begin
                        ram_en = 1'b1;
                        rd_d   = 1'b1;
                    end
                end else begin
                    rd_d = 1'b0;
                    if (ch_is_hex) begin
                        data_d  = {hi_q, ch_nibble};
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_BAD_HEX;
                    end
                end
            end

            S_EMIT: begin
                if (out_ready) begin
                    idx_d   = idx_q + IDX_W'(1);
                    nl_d    = 1'b0;
                    state_d = (idx_q == IDX_LAST) ? S_DONE : S_HI;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ram_addr  = addr_q;
    assign out_valid = (state_q == S_EMIT);
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign err_code  = code_q;

endmodule

// File: tb/tb_matx_hex_parser.sv
// Directed bench for matx_hex_parser: a table of buffer layouts with expected outcomes,
// plus hand-written sequences for reset, tag-not-found with restart, and reset during EMIT.
module tb_matx_hex_parser;

    localparam int ADDR_W  = 9;
    localparam int N_BYTES = 32;
    localparam int IDX_W   = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic [7:0]        ram_dout;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    always #5 clk = ~clk;

    matx_hex_parser #(.ADDR_W(ADDR_W), .N_BYTES(N_BYTES), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_dout  (ram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    // Sector buffer model: one-cycle synchronous read.
    logic [7:0] mem [512];
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    logic [7:0] payload [32] = '{
        8'hE1, 8'h6B, 8'hD7, 8'h02, 8'hA5, 8'h3C, 8'h90, 8'hFF,
        8'h00, 8'h17, 8'h4E, 8'h8D, 8'hB2, 8'h59, 8'hC6, 8'h21,
        8'h7A, 8'h0F, 8'h38, 8'hE4, 8'h95, 8'h1D, 8'h6F, 8'hA0,
        8'h44, 8'hBB, 8'h0C, 8'h83, 8'hF1, 8'h2E, 8'h5A, 8'hD3
    };

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshake monitor and stall-stability checker, sampled on the falling edge.
    logic [7:0]       got_data [$];
    logic [IDX_W-1:0] got_idx  [$];
    logic             stalled_q = 1'b0;
    logic [7:0]       held_data;
    logic [IDX_W-1:0] held_idx;

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_q <= 1'b0;
        end else begin
            if (stalled_q) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, held_data});
                check("stall_idx", {27'd0, out_idx}, {27'd0, held_idx});
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_idx.push_back(out_idx);
            end
            stalled_q <= out_valid && !out_ready;
            held_data <= out_data;
            held_idx  <= out_idx;
        end
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic put(input int addr, input logic [7:0] c);
        if (addr < 512) mem[addr] = c;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    endtask

    task automatic build_buffer(input int tag_addr, input bit double_m, input int bad_line,
                                input int lower_line, input int blank_after);
        logic [63:0] tag;
        logic [7:0]  c0, c1;
        int p;
        tag = "MATX_TAG";
        clear_mem();
        p = tag_addr;
        if (double_m) begin put(p, 8'h4D); p++; end
        for (int k = 0; k < 8; k++) put(p + k, tag[8*(7-k) +: 8]);
        p += 8;
        put(p, 8'h0D); put(p + 1, 8'h0A); p += 2;
        for (int i = 0; i < 32; i++) begin
            if (i == blank_after) begin put(p, 8'h0D); put(p + 1, 8'h0A); p += 2; end
            c0 = hexc(payload[i][7:4]);
            c1 = hexc(payload[i][3:0]);
            if (i == bad_line)   c0 = 8'h47;
            if (i == lower_line) c0 = c0 | 8'h20;
            put(p, c0); put(p + 1, c1); put(p + 2, 8'h0D); put(p + 3, 8'h0A);
            p += 4;
        end
        put(p, 8'h0D); put(p + 1, 8'h0A);
    endtask

    // Pulse start, then run until done/err with a bounded cycle budget.
    task automatic run_parse(input string name, input int mode);
        got_data.delete();
        got_idx.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(posedge clk); #1;
            if (done || err) break;
        end
        check({name, "_finished"}, {31'd0, done || err}, 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic compare_run(input string name, input int exp_count, input bit exp_done,
                               input logic [1:0] exp_code);
        check({name, "_count"}, got_data.size(), exp_count);
        for (int i = 0; i < exp_count && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), {24'd0, got_data[i]}, {24'd0, payload[i]});
            check($sformatf("%s_idx%0d", name, i), {27'd0, got_idx[i]}, i);
        end
        check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({name, "_err"}, {31'd0, err}, {31'd0, !exp_done});
        check({name, "_code"}, {30'd0, err_code}, {30'd0, exp_code});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_addr"}, {23'd0, ram_addr}, 32'd0);
        check({name, "_en"}, {31'd0, ram_en}, 32'd0);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_data"}, {24'd0, out_data}, 32'd0);
        check({name, "_idx"}, {27'd0, out_idx}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_err"}, {31'd0, err}, 32'd0);
        check({name, "_code"}, {30'd0, err_code}, 32'd0);
    endtask

    typedef struct {
        string      name;
        int         tag_addr;
        bit         double_m;
        int         bad_line;
        int         lower_line;
        int         blank_after;
        int         ready_mode;
        int         exp_count;
        bit         exp_done;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{"nominal",   0,   1'b0, -1, -1, -1, 0, 32, 1'b1, 2'd0};
        vecs[1] = '{"stall",     0,   1'b0, -1, -1, -1, 1, 32, 1'b1, 2'd0};
        vecs[2] = '{"double_m",  5,   1'b1, -1, -1, -1, 0, 32, 1'b1, 2'd0};
        vecs[3] = '{"bad_g4",    0,   1'b0,  2, -1, -1, 0,  2, 1'b0, 2'd2};
`ifdef MATX_PARSER_LOWERCASE_EN
        vecs[4] = '{"lower_e1",  0,   1'b0, -1,  0, -1, 0, 32, 1'b1, 2'd0};
`else
        vecs[4] = '{"lower_e1",  0,   1'b0, -1,  0, -1, 0,  0, 1'b0, 2'd2};
`endif
        vecs[5] = '{"blank10",   0,   1'b0, -1, -1, 10, 0, 10, 1'b0, 2'd3};
        vecs[6] = '{"end_buf",   400, 1'b0, -1, -1, -1, 0, 26, 1'b0, 2'd3};

        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            build_buffer(vecs[v].tag_addr, vecs[v].double_m, vecs[v].bad_line,
                         vecs[v].lower_line, vecs[v].blank_after);
            run_parse(vecs[v].name, vecs[v].ready_mode);
            compare_run(vecs[v].name, vecs[v].exp_count, vecs[v].exp_done, vecs[v].exp_code);
        end

        // Tag never found: error after address 511, no emitted bytes, address held at the end.
        clear_mem();
        run_parse("notag", 0);
        compare_run("notag", 0, 1'b0, 2'd1);
        check("notag_addr", {23'd0, ram_addr}, 32'd511);
        build_buffer(0, 1'b0, -1, -1, -1);
        run_parse("restart", 0);
        compare_run("restart", 32, 1'b1, 2'd0);

        // Reset while a byte is waiting in EMIT, then a clean full parse.
        out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (out_valid) break;
            @(posedge clk); #1;
        end
        check("rst_emit_reached", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_emit");
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_emit_idle_valid", {31'd0, out_valid}, 32'd0);
        run_parse("post_rst", 0);
        compare_run("post_rst", 32, 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
